// File: rtl/retire_buffer.sv
// retire_buffer: in-order retirement queue downstream of the register renamer.
// Entries are {old_phys, new_phys} pairs. An entry is marked done by tag and commits
// in program order, freeing old_phys. A flush walks the queue youngest-first and frees
// each squashed new_phys. retire_out/retire_ena_out drive the renamer retire port.
module retire_buffer #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int PREG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  alloc_valid,
    input  logic [2*PREG_W-1:0]   alloc_wbs,
    output logic                  alloc_ready,
    output logic [TAG_W-1:0]      alloc_tag,
    input  logic                  done_valid,
    input  logic [TAG_W-1:0]      done_tag,
    input  logic                  flush,
    output logic [PREG_W-1:0]     retire_out,
    output logic                  retire_ena_out,
    output logic                  commit_valid,
    output logic [TAG_W:0]        count,
    output logic                  empty,
    output logic                  busy
);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_e;

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    state_e              state_q, state_d;
    // Pointers carry one extra wrap bit so that full and empty are distinguishable.
    logic [TAG_W:0]      head_q, head_d;
    logic [TAG_W:0]      tail_q, tail_d;
    logic [DEPTH-1:0]    done_q, done_d;
    logic [PREG_W-1:0]   old_q [DEPTH];
    logic [PREG_W-1:0]   new_q [DEPTH];
    logic [PREG_W-1:0]   retire_q, retire_d;
    logic                retire_ena_q, retire_ena_d;
    logic                commit_valid_q, commit_valid_d;

    logic                run_active;
    logic                flush_take;
    logic                accept;
    logic                commit;
    logic                done_hit;
    logic                walk;
    logic [TAG_W-1:0]    done_rel;
    logic [TAG_W:0]      walk_tail;
    logic [TAG_W-1:0]    head_idx;
    logic [TAG_W-1:0]    tail_idx;

    assign count          = tail_q - head_q;
    assign empty          = (count == '0);
    assign busy           = (state_q == ST_FLUSH);
    assign alloc_ready    = (state_q == ST_RUN) && (count < DEPTH_CNT) && !flush;
    assign alloc_tag      = tail_q[TAG_W-1:0];
    assign retire_out     = retire_q;
    assign retire_ena_out = retire_ena_q;
    assign commit_valid   = commit_valid_q;

    assign head_idx   = head_q[TAG_W-1:0];
    assign tail_idx   = tail_q[TAG_W-1:0];
    // A RUN cycle in which flush is absent: done marking, commit and allocation may act.
    assign run_active = (state_q == ST_RUN) && ena && !flush;
    assign flush_take = (state_q == ST_RUN) && ena && flush && !empty;
    assign accept     = alloc_valid && alloc_ready && ena;
    assign commit     = run_active && !empty && done_q[head_idx];
    // Distance of the completed tag from head; it is live only if it lies below count.
    assign done_rel   = done_tag - head_idx;
    assign done_hit   = run_active && done_valid && ({1'b0, done_rel} < count);
    assign walk       = (state_q == ST_FLUSH) && ena;
    assign walk_tail  = tail_q - 1'b1;

    // Next-state logic: pointers, done bits, retire port and the RUN/FLUSH state.
    always_comb begin
        // NOTE: every target gets a default before any branch, so no latch can be inferred.
        state_d        = state_q;
        head_d         = head_q;
        tail_d         = tail_q;
        done_d         = done_q;
        retire_d       = retire_q;
        retire_ena_d   = 1'b0;
        commit_valid_d = 1'b0;

        if (state_q == ST_RUN) begin
            if (flush_take) begin
                state_d = ST_FLUSH;
            end
            if (done_hit) begin
                done_d[done_tag] = 1'b1;
            end
            if (commit) begin
                head_d         = head_q + 1'b1;
                retire_d       = old_q[head_idx];
                retire_ena_d   = (old_q[head_idx] != '0);
                commit_valid_d = 1'b1;
            end
            if (accept) begin
                tail_d           = tail_q + 1'b1;
                done_d[tail_idx] = 1'b0;
            end
        end else if (walk) begin
            tail_d       = walk_tail;
            retire_d     = new_q[walk_tail[TAG_W-1:0]];
            retire_ena_d = (new_q[walk_tail[TAG_W-1:0]] != '0);
            if (walk_tail == head_q) begin
                state_d = ST_RUN;
            end
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q        <= ST_RUN;
            head_q         <= '0;
            tail_q         <= '0;
            done_q         <= '0;
            retire_q       <= '0;
            retire_ena_q   <= 1'b0;
            commit_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            done_q         <= done_d;
            retire_q       <= retire_d;
            retire_ena_q   <= retire_ena_d;
            commit_valid_q <= commit_valid_d;
        end
    end

    // Entry payload storage, written on accepted allocation.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; an entry is only read after allocation has written it.
        if (accept) begin
            old_q[tail_idx] <= alloc_wbs[2*PREG_W-1:PREG_W];
            new_q[tail_idx] <= alloc_wbs[PREG_W-1:0];
        end
    end

endmodule
